// File: rtl/mar_seq_pkg.sv
// Shared types and default parameters for the memory-address-register sequencer.
`timescale 1ns/1ps
package mar_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_TMO_CYC = 8;

  // Counter width able to hold 0..tmo-1, never narrower than one bit.
  function automatic int cnt_width(input int tmo);
    return (tmo <= 2) ? 1 : $clog2(tmo);
  endfunction

endpackage

// File: rtl/mar_seq_if.sv
// Control and memory-side bus between the sequencer and its controller.
`timescale 1ns/1ps
interface mar_seq_if
  import mar_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              en;
  logic              ld_pc;
  logic              ld_ir;
  logic              inc;
  logic [ADDR_W-1:0] addr_pc;
  logic [ADDR_W-1:0] addr_ir;
  logic              rd_start;
  logic              mem_ack;
  logic              err_clr;
  logic [ADDR_W-1:0] addr_out;
  logic              mem_req;
  logic              busy;
  logic              rd_done;
  logic              wrap;
  logic              load_drop;
  logic              tmo_err;

  modport master (
    output en, ld_pc, ld_ir, inc, addr_pc, addr_ir, rd_start, mem_ack, err_clr,
    input  addr_out, mem_req, busy, rd_done, wrap, load_drop, tmo_err
  );

  modport slave (
    input  en, ld_pc, ld_ir, inc, addr_pc, addr_ir, rd_start, mem_ack, err_clr,
    output addr_out, mem_req, busy, rd_done, wrap, load_drop, tmo_err
  );

endinterface

// File: rtl/mar_tmo_cnt.sv
// Read-wait counter; tc flags the last allowed cycle without acknowledge.
`timescale 1ns/1ps
module mar_tmo_cnt
  import mar_seq_pkg::*;
#(
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            CW   = cnt_width(TMO_CYC);
  localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= cnt + 1'b1;
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/mar_seq.sv
// Memory address register with load/increment and a single-outstanding read FSM with timeout.
`timescale 1ns/1ps
module mar_seq
  import mar_seq_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  mar_seq_if.slave   bus
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              mem_req;
  logic              busy;
  logic              rd_done;
  logic              wrap;
  logic              load_drop;
  logic              tmo_err;
  logic              upd_any;
  logic              upd_ok;
  logic              cnt_en;
  logic              cnt_clr;
  logic              tmo_tc;

  assign upd_any = bus.ld_pc | bus.ld_ir | bus.inc;
  assign upd_ok  = bus.en && (state != ST_REQ);
  // Ack beats timeout: an acked cycle never advances the counter.
  assign cnt_en  = (state == ST_REQ) && !bus.mem_ack;
  assign cnt_clr = (state != ST_REQ) || bus.mem_ack || tmo_tc;

  mar_tmo_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (tmo_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      rd_done   <= 1'b0;
      wrap      <= 1'b0;
      load_drop <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      rd_done   <= 1'b0;
      wrap      <= 1'b0;
      load_drop <= bus.en && (state == ST_REQ) && upd_any;
      if (upd_ok) begin
        if (bus.ld_pc)      addr <= bus.addr_pc;
        else if (bus.ld_ir) addr <= bus.addr_ir;
        else if (bus.inc) begin
          addr <= addr + 1'b1;
          wrap <= (addr == ADDR_MAX);
        end
      end
      case (state)
        ST_IDLE: begin
          if (bus.en && bus.rd_start) begin
            state   <= ST_REQ;
            mem_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            rd_done <= 1'b1;
          end else if (tmo_tc) begin
            state   <= ST_ERR;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            tmo_err <= 1'b1;
          end
        end
        ST_ERR: begin
          if (bus.err_clr) begin
            state   <= ST_IDLE;
            tmo_err <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
          tmo_err <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr_out  = addr;
  assign bus.mem_req   = mem_req;
  assign bus.busy      = busy;
  assign bus.rd_done   = rd_done;
  assign bus.wrap      = wrap;
  assign bus.load_drop = load_drop;
  assign bus.tmo_err   = tmo_err;

endmodule

// File: tb/tb_mar_seq.sv
// Self-checking bench for mar_seq: directed table, corner sequences, random run against a model.
`timescale 1ns/1ps
module tb_mar_seq;
  import mar_seq_pkg::*;

  localparam int AW   = 4;
  localparam int TMO  = 8;
  localparam int SPAN = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mar_seq_if #(.ADDR_W(AW)) bus ();

  mar_seq #(.ADDR_W(AW), .TMO_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: mode, address as an integer, cycles spent waiting.
  typedef enum int {M_IDLE, M_REQ, M_ERR} mmode_t;
  mmode_t m_mode;
  int     m_addr;
  int     m_waited;
  bit     e_done, e_wrap, e_drop;

  typedef struct {
    string          name;
    bit             en, ld_pc, ld_ir, inc, rd, ack, clr;
    logic [AW-1:0]  pc, ir, e_addr;
    bit             e_req, e_busy, e_done, e_wrap, e_drop, e_err;
  } vec_t;
  vec_t vt[$];

  function automatic void add_vec(string nm, bit en, bit lp, bit li, bit in, bit rd, bit ack, bit clr,
                                  int pc, int ir, int ea, bit rq, bit bz, bit dn, bit wr, bit dr, bit er);
    vec_t v;
    v.name = nm; v.en = en; v.ld_pc = lp; v.ld_ir = li; v.inc = in; v.rd = rd; v.ack = ack; v.clr = clr;
    v.pc = AW'(pc); v.ir = AW'(ir); v.e_addr = AW'(ea);
    v.e_req = rq; v.e_busy = bz; v.e_done = dn; v.e_wrap = wr; v.e_drop = dr; v.e_err = er;
    vt.push_back(v);
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_addr = 0; m_waited = 0;
    e_done = 0; e_wrap = 0; e_drop = 0;
  endfunction

  function automatic void model_step();
    e_done = 0; e_wrap = 0;
    e_drop = bus.en && (m_mode == M_REQ) && (bus.ld_pc || bus.ld_ir || bus.inc);
    if (bus.en && m_mode != M_REQ) begin
      if (bus.ld_pc)      m_addr = int'(bus.addr_pc);
      else if (bus.ld_ir) m_addr = int'(bus.addr_ir);
      else if (bus.inc) begin
        e_wrap = (m_addr == SPAN - 1);
        m_addr = (m_addr + 1) % SPAN;
      end
    end
    case (m_mode)
      M_IDLE: if (bus.en && bus.rd_start) begin m_mode = M_REQ; m_waited = 0; end
      M_REQ: begin
        if (bus.mem_ack) begin m_mode = M_IDLE; e_done = 1; end
        else begin
          m_waited++;
          if (m_waited == TMO) m_mode = M_ERR;
        end
      end
      default: if (bus.err_clr) m_mode = M_IDLE;
    endcase
  endfunction

  function automatic logic [AW+5:0] act_vec();
    return {bus.addr_out, bus.mem_req, bus.busy, bus.rd_done, bus.wrap, bus.load_drop, bus.tmo_err};
  endfunction

  function automatic logic [AW+5:0] model_vec();
    return {AW'(m_addr), m_mode == M_REQ, m_mode == M_REQ, e_done, e_wrap, e_drop, m_mode == M_ERR};
  endfunction

  task automatic check(input string nm, input logic [AW+5:0] exp);
    logic [AW+5:0] act;
    act = act_vec();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: actual {addr,req,busy,done,wrap,drop,err}=%b required=%b", nm, $time, act, exp);
    end
  endtask

  task automatic check_ctl(input string nm, input bit rq, input bit bz, input bit dn, input bit er);
    logic [3:0] act;
    act = {bus.mem_req, bus.busy, bus.rd_done, bus.tmo_err};
    n_tests++;
    if (act !== {rq, bz, dn, er}) begin
      n_fail++;
      $display("FAIL %s t=%0t: actual {req,busy,done,err}=%b required=%b", nm, $time, act, {rq, bz, dn, er});
    end
  endtask

  task automatic set_in(input bit en, input bit lp, input bit li, input bit in, input bit rd,
                        input bit ack, input bit clr, input logic [AW-1:0] pc, input logic [AW-1:0] ir);
    bus.en = en; bus.ld_pc = lp; bus.ld_ir = li; bus.inc = in; bus.rd_start = rd;
    bus.mem_ack = ack; bus.err_clr = clr; bus.addr_pc = pc; bus.addr_ir = ir;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_tick();
    set_in(0, 0, 0, 0, 0, 0, 0, '0, '0);
    tick();
  endtask

  initial begin
    //       name         en lp li in rd ak cl  pc   ir   addr rq bz dn wr dr er
    add_vec("pc_prio",    1, 1, 1, 0, 0, 0, 0, 'h3, 'h9, 'h3, 0, 0, 0, 0, 0, 0);
    add_vec("en_block",   0, 1, 0, 0, 0, 0, 0, 'h5, 'h0, 'h3, 0, 0, 0, 0, 0, 0);
    add_vec("ld_ir",      1, 0, 1, 0, 0, 0, 0, 'h0, 'hF, 'hF, 0, 0, 0, 0, 0, 0);
    add_vec("inc_wrap",   1, 0, 0, 1, 0, 0, 0, 'h0, 'h0, 'h0, 0, 0, 0, 1, 0, 0);
    add_vec("inc_nowrap", 1, 0, 0, 1, 0, 0, 0, 'h0, 'h0, 'h1, 0, 0, 0, 0, 0, 0);
    add_vec("en0_rd",     0, 0, 0, 1, 1, 0, 0, 'h0, 'h0, 'h1, 0, 0, 0, 0, 0, 0);
    add_vec("ldir_rd",    1, 0, 1, 0, 1, 0, 0, 'h0, 'h6, 'h6, 1, 1, 0, 0, 0, 0);
    add_vec("req_ldpc",   1, 1, 0, 0, 0, 0, 0, 'hA, 'h0, 'h6, 1, 1, 0, 0, 1, 0);
    add_vec("req_wait",   0, 0, 0, 0, 0, 0, 0, 'h0, 'h0, 'h6, 1, 1, 0, 0, 0, 0);
    add_vec("req_ack",    0, 0, 0, 0, 0, 1, 0, 'h0, 'h0, 'h6, 0, 0, 1, 0, 0, 0);
    add_vec("done_fall",  0, 0, 0, 0, 0, 0, 0, 'h0, 'h0, 'h6, 0, 0, 0, 0, 0, 0);
    add_vec("stray_ack",  1, 0, 0, 0, 0, 1, 1, 'h0, 'h0, 'h6, 0, 0, 0, 0, 0, 0);
    add_vec("inc7",       1, 0, 0, 1, 0, 0, 0, 'h0, 'h0, 'h7, 0, 0, 0, 0, 0, 0);
    add_vec("en0_rd2",    0, 0, 0, 0, 1, 0, 0, 'h0, 'h0, 'h7, 0, 0, 0, 0, 0, 0);
    add_vec("inc_rd",     1, 0, 0, 1, 1, 0, 0, 'h0, 'h0, 'h8, 1, 1, 0, 0, 0, 0);
    add_vec("ack_en0",    0, 0, 0, 1, 0, 1, 0, 'h0, 'h0, 'h8, 0, 0, 1, 0, 0, 0);
    add_vec("inc9",       1, 0, 0, 1, 0, 0, 0, 'h0, 'h0, 'h9, 0, 0, 0, 0, 0, 0);

    set_in(0, 0, 0, 0, 0, 0, 0, '0, '0);
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", '0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      set_in(vt[i].en, vt[i].ld_pc, vt[i].ld_ir, vt[i].inc, vt[i].rd, vt[i].ack, vt[i].clr, vt[i].pc, vt[i].ir);
      tick();
      check(vt[i].name, {vt[i].e_addr, vt[i].e_req, vt[i].e_busy, vt[i].e_done,
                         vt[i].e_wrap, vt[i].e_drop, vt[i].e_err});
    end

    // Timeout after TMO waiting cycles, ERR behaviour, clear.
    set_in(1, 0, 0, 0, 1, 0, 0, '0, '0);
    tick();
    check_ctl("tmo_enter", 1, 1, 0, 0);
    for (int k = 1; k < TMO; k++) begin
      idle_tick();
      check_ctl("tmo_wait", 1, 1, 0, 0);
    end
    idle_tick();
    check_ctl("tmo_hit", 0, 0, 0, 1);
    check("tmo_hit_full", model_vec());
    set_in(1, 0, 0, 0, 1, 0, 0, '0, '0);
    tick();
    check_ctl("err_rd_ignored", 0, 0, 0, 1);
    set_in(1, 0, 0, 1, 0, 1, 0, '0, '0);
    tick();
    check("err_inc_ok", model_vec());
    set_in(0, 0, 0, 0, 0, 0, 1, '0, '0);
    tick();
    check_ctl("err_clr", 0, 0, 0, 0);

    // Ack arriving on the last allowed cycle wins over timeout.
    set_in(1, 0, 0, 0, 1, 0, 0, '0, '0);
    tick();
    for (int k = 1; k < TMO; k++) idle_tick();
    check_ctl("limit_still_req", 1, 1, 0, 0);
    set_in(0, 0, 0, 0, 0, 1, 0, '0, '0);
    tick();
    check_ctl("limit_ack_wins", 0, 0, 1, 0);
    check("limit_ack_full", model_vec());

    // Short asynchronous reset in the middle of a read.
    set_in(1, 0, 1, 0, 1, 0, 0, '0, 4'hC);
    tick();
    check_ctl("rst_req_up", 1, 1, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, '0, '0);
    #2;
    rst_n = 1'b0;
    #0.5;
    check("rst_async", '0);
    model_reset();
    #0.5;
    rst_n = 1'b1;
    tick();
    check("rst_no_done", '0);
    idle_tick();
    check("rst_idle", model_vec());

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      set_in($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 20, AW'($urandom), AW'($urandom));
      tick();
      check("random", model_vec());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
